// File: rtl/mopa_unit.sv
// mopa_unit: DIM x DIM outer-product tile engine.
//   A request carries an op, a signedness flag, A/B vectors and a C tile.
//   The unit computes C op A*B one row per cycle and then presents the tile
//   until the consumer takes it.
//   Ops: 00 MOPA (C+=A*B), 01 MOPS (C-=A*B), 10 MOP (C=A*B), 11 CLR (C=0).
// Ports:
//   clk, rstn                  clock, async active-low reset
//   in_valid/in_ready          request handshake (ready only while idle)
//   in_op, in_signed           operation and element signedness
//   in_a, in_b                 DIM elements of EW bits, element k at [k*EW +: EW]
//   in_c                       tile, element (i,j) at [(i*DIM+j)*ACC_W +: ACC_W]
//   out_valid/out_ready        result handshake
//   out_c                      result tile, same layout as in_c
//   busy                       high whenever the unit is not idle

// Per-column element update: one (i,j) cell of the row being processed.
module mopa_lane #(
  parameter int EW    = 8,
  parameter int ACC_W = 8
) (
  input  logic [1:0]       op,
  input  logic             sgn,
  input  logic [EW-1:0]    a,
  input  logic [EW-1:0]    b,
  input  logic [ACC_W-1:0] c,
  output logic [ACC_W-1:0] res
);
  localparam int PW = 2 * EW;

  logic [PW-1:0]    ax, bx, prod;
  logic [ACC_W-1:0] p;

  // Extending both operands to the full product width makes the low PW bits
  // of a plain multiply correct for both signed and unsigned operands.
  always_comb begin
    ax   = sgn ? {{EW{a[EW-1]}}, a} : {{EW{1'b0}}, a};
    bx   = sgn ? {{EW{b[EW-1]}}, b} : {{EW{1'b0}}, b};
    prod = ax * bx;
  end

  generate
    if (ACC_W > PW) begin : g_ext
      assign p = {{(ACC_W-PW){sgn & prod[PW-1]}}, prod};
    end else begin : g_trunc
      assign p = prod[ACC_W-1:0];
    end
  endgenerate

  // Everything wraps modulo 2^ACC_W.
  always_comb begin
    res = '0;
    case (op)
      2'b00:   res = c + p;
      2'b01:   res = c - p;
      2'b10:   res = p;
      default: res = '0;
    endcase
  end
endmodule

module mopa_unit #(
  parameter int DIM   = 4,
  parameter int EW    = 8,
  parameter int ACC_W = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_op,
  input  logic                     in_signed,
  input  logic [DIM*EW-1:0]        in_a,
  input  logic [DIM*EW-1:0]        in_b,
  input  logic [DIM*DIM*ACC_W-1:0] in_c,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DIM*DIM*ACC_W-1:0] out_c,
  output logic                     busy
);
  localparam int         RW     = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [1:0] OP_CLR = 2'b11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic [1:0]              op;
    logic                    sgn;
    logic [DIM-1:0][EW-1:0]  a;
    logic [DIM-1:0][EW-1:0]  b;
  } req_t;

  state_t                             state_q, state_d;
  req_t                               req_q;
  logic [RW-1:0]                      row_q;
  logic [DIM-1:0][DIM-1:0][ACC_W-1:0] tile_q;
  logic [DIM-1:0][ACC_W-1:0]          row_res;
  logic                               accept, last_row;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_c     = tile_q;
  assign accept    = in_valid & in_ready;
  assign last_row  = (row_q == RW'(DIM-1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (in_op == OP_CLR) ? DONE : BUSY;
      BUSY: if (last_row) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The tile register doubles as the accumulator: it is loaded with in_c on
  // accept and rewritten one row per BUSY cycle, so out_c is simply its value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_q  <= '0;
      row_q  <= '0;
      tile_q <= '0;
    end else if (accept) begin
      req_q  <= '{op: in_op, sgn: in_signed, a: in_a, b: in_b};
      row_q  <= '0;
      tile_q <= (in_op == OP_CLR) ? '0 : in_c;
    end else if (state_q == BUSY) begin
      tile_q[row_q] <= row_res;
      row_q         <= last_row ? '0 : row_q + RW'(1);
    end
  end

  generate
    for (genvar j = 0; j < DIM; j++) begin : g_lane
      mopa_lane #(.EW(EW), .ACC_W(ACC_W)) u_lane (
        .op  (req_q.op),
        .sgn (req_q.sgn),
        .a   (req_q.a[row_q]),
        .b   (req_q.b[j]),
        .c   (tile_q[row_q][j]),
        .res (row_res[j])
      );
    end
  endgenerate
endmodule

// File: tb/tb_mopa_unit.sv
// Bench for mopa_unit: directed table, randomized requests against a plain
// arithmetic model, reset-in-flight sequence and a 16-bit accumulator instance.
module tb_mopa_unit;
  localparam int DIM = 4, EW = 8, ACC_W = 8;
  localparam int AW  = DIM*EW, CW = DIM*DIM*ACC_W;
  localparam int CW16 = DIM*DIM*16;

  logic clk, rstn;
  logic in_valid, in_ready, in_signed, out_valid, out_ready, busy;
  logic [1:0]    in_op;
  logic [AW-1:0] in_a, in_b;
  logic [CW-1:0] in_c, out_c;

  logic in_valid_w, in_ready_w, in_signed_w, out_valid_w, out_ready_w, busy_w;
  logic [1:0]      in_op_w;
  logic [AW-1:0]   in_a_w, in_b_w;
  logic [CW16-1:0] in_c_w, out_c_w;

  int checks = 0, failures = 0;

  mopa_unit dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_signed(in_signed), .in_a(in_a), .in_b(in_b),
    .in_c(in_c), .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .busy(busy)
  );

  mopa_unit #(.DIM(DIM), .EW(EW), .ACC_W(16)) dut16 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .in_op(in_op_w), .in_signed(in_signed_w), .in_a(in_a_w), .in_b(in_b_w),
    .in_c(in_c_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
    .out_c(out_c_w), .busy(busy_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: every element is the true integer result reduced mod 2^ACC_W.
  function automatic logic [CW-1:0] model(input logic [1:0] op, input logic sgn,
                                          input logic [AW-1:0] a, input logic [AW-1:0] b,
                                          input logic [CW-1:0] c);
    logic [CW-1:0] t;
    longint av, bv, cv, r;
    t = '0;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        av = longint'(a[i*EW +: EW]);
        bv = longint'(b[j*EW +: EW]);
        if (sgn && av >= (longint'(1) << (EW-1))) av -= longint'(1) << EW;
        if (sgn && bv >= (longint'(1) << (EW-1))) bv -= longint'(1) << EW;
        cv = longint'(c[(i*DIM+j)*ACC_W +: ACC_W]);
        case (op)
          2'b00:   r = cv + av*bv;
          2'b01:   r = cv - av*bv;
          2'b10:   r = av*bv;
          default: r = 0;
        endcase
        t[(i*DIM+j)*ACC_W +: ACC_W] = r[ACC_W-1:0];
      end
    return t;
  endfunction

  // One full transaction; holds DONE for 'hold' cycles with junk requests.
  task automatic do_req(input logic [1:0] op, input logic sgn, input logic [AW-1:0] a,
                        input logic [AW-1:0] b, input logic [CW-1:0] c, input int hold,
                        output logic [CW-1:0] res);
    int lat;
    @(negedge clk);
    check("idle_ready", 128'(in_ready), 128'(1));
    in_valid = 1'b1; in_op = op; in_signed = sgn; in_a = a; in_b = b; in_c = c;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom;
    check("busy_after_accept", 128'(busy), 128'(1));
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    // Edges after the accept edge: CLR is visible right after accept.
    check("latency", 128'(lat), 128'((op == 2'b11) ? 0 : DIM));
    check("out_valid", 128'(out_valid), 128'(1));
    res = out_c;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_op = 2'($urandom); in_signed = 1'($urandom);
      in_a = $urandom; in_b = $urandom;
      in_c = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      check("hold_valid", 128'(out_valid), 128'(1));
      check("hold_ready", 128'(in_ready), 128'(0));
      check("hold_data", 128'(out_c), 128'(res));
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_hs_valid", 128'(out_valid), 128'(0));
    check("post_hs_ready", 128'(in_ready), 128'(1));
    check("post_hs_retain", 128'(out_c), 128'(res));
  endtask

  task automatic run16(input logic sgn, input logic [15:0] exp);
    int n;
    @(negedge clk);
    in_valid_w = 1'b1; in_op_w = 2'b10; in_signed_w = sgn;
    in_a_w = 32'h000000FF; in_b_w = 32'h00000002;
    in_c_w = {8{$urandom}};
    @(posedge clk); #1;
    in_valid_w = 1'b0;
    n = 0;
    while (!out_valid_w && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("w16_latency", 128'(n), 128'(DIM));
    check("w16_c00", 128'(out_c_w[15:0]), 128'(exp));
    check("w16_c11", 128'(out_c_w[(1*DIM+1)*16 +: 16]), 128'(0));
    @(negedge clk); out_ready_w = 1'b1;
    @(posedge clk); #1; out_ready_w = 1'b0;
    check("w16_idle", 128'(in_ready_w), 128'(1));
  endtask

  typedef struct {
    logic [1:0]    op;
    logic          sgn;
    logic [AW-1:0] a, b;
    logic [CW-1:0] c, exp;
    int            hold;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [CW-1:0] res, exp_c;
    logic [1:0]    op;
    logic          sgn;
    logic [AW-1:0] a, b;
    logic [CW-1:0] c;

    vecs[0] = '{op: 2'b00, sgn: 1'b0, a: 32'h04030201, b: 32'h01010101,
                c: {16{8'h10}}, exp: 128'h14141414_13131313_12121212_11111111, hold: 0};
    vecs[1] = '{op: 2'b01, sgn: 1'b0, a: 32'h01010101, b: 32'h01010101,
                c: '0, exp: {16{8'hFF}}, hold: 2};
    vecs[2] = '{op: 2'b11, sgn: 1'b0, a: 32'h12345678, b: 32'h9ABCDEF0,
                c: 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, exp: '0, hold: 1};
    vecs[3] = '{op: 2'b10, sgn: 1'b1, a: 32'h000000FF, b: 32'h00000002,
                c: {16{8'h5A}}, exp: 128'h000000FE, hold: 0};
    vecs[4] = '{op: 2'b00, sgn: 1'b1, a: 32'h000000FF, b: 32'h00000003,
                c: {16{8'h05}}, exp: 128'h05050505_05050505_05050505_05050502, hold: 10};

    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_op = '0; in_signed = 1'b0;
    in_a = '0; in_b = '0; in_c = {4{32'hA5A5A5A5}};
    in_valid_w = 1'b0; out_ready_w = 1'b0; in_op_w = '0; in_signed_w = 1'b0;
    in_a_w = '0; in_b_w = '0; in_c_w = '0;
    #2;
    check("rst_valid", 128'(out_valid), 128'(0));
    check("rst_ready", 128'(in_ready), 128'(1));
    check("rst_busy",  128'(busy), 128'(0));
    check("rst_out_c", 128'(out_c), 128'(0));
    @(negedge clk); rstn = 1'b1;

    foreach (vecs[k]) begin
      do_req(vecs[k].op, vecs[k].sgn, vecs[k].a, vecs[k].b, vecs[k].c, vecs[k].hold, res);
      check($sformatf("vec%0d_tile", k), 128'(res), 128'(vecs[k].exp));
    end

    for (int k = 0; k < 25; k++) begin
      op = 2'($urandom); sgn = 1'($urandom);
      a = $urandom; b = $urandom; c = {$urandom, $urandom, $urandom, $urandom};
      exp_c = model(op, sgn, a, b, c);
      do_req(op, sgn, a, b, c, int'($urandom_range(0, 2)), res);
      check($sformatf("rand%0d_tile", k), 128'(res), 128'(exp_c));
    end

    // Reset while processing row 2.
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'b00; in_signed = 1'b0;
    in_a = $urandom; in_b = $urandom; in_c = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("mid_busy", 128'(busy), 128'(1));
    rstn = 1'b0; #1;
    check("midrst_valid", 128'(out_valid), 128'(0));
    check("midrst_out_c", 128'(out_c), 128'(0));
    check("midrst_ready", 128'(in_ready), 128'(1));
    check("midrst_busy",  128'(busy), 128'(0));
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    check("postrst_valid", 128'(out_valid), 128'(0));
    a = $urandom; b = $urandom; c = {$urandom, $urandom, $urandom, $urandom};
    exp_c = model(2'b00, 1'b1, a, b, c);
    do_req(2'b00, 1'b1, a, b, c, 0, res);
    check("postrst_tile", 128'(res), 128'(exp_c));

    run16(1'b1, 16'hFFFE);
    run16(1'b0, 16'h01FE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
